pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Parametrised program-counter sequencer for the RISC-V instruction decoder path.
//  Generalises the boot-load / +4 / override counter with the following additions:
//   - configurable width and step;
//   - valid/ready handshake towards fetch;
//   - prioritised trap and redirect inputs, with misaligned-target detection;
//   - halt/resume control;
//   - a count of accepted fetches.
// PARAMETERS
//  XLEN        32  PC / address width in bits
//  STEP        4   increment applied on each accepted fetch
//  ALIGN_BITS  2   low address bits that must be zero on a redirect (0 = no check)
//  CNT_W       32  width of fetch_count
// PORTS
//  clk             in   1      clock, rising edge
//  rst             in   1      reset, asynchronous, active-high
//  boot_addr       in   XLEN   first PC after reset; sampled in BOOT only
//  trap_vec        in   XLEN   trap target address
//  trap_req        in   1      take trap this cycle
//  redirect_valid  in   1      branch/jump redirect this cycle
//  redirect_addr   in   XLEN   redirect target
//  halt_req        in   1      stop issuing PCs
//  resume_req      in   1      leave HALT
//  pc_ready        in   1      fetch accepts pc this cycle
//  pc_valid        out  1      pc is valid for fetch
//  pc              out  XLEN   current program counter
//  misaligned      out  1      one-cycle pulse: rejected misaligned redirect
//  misaligned_addr out  XLEN   offending redirect_addr; held until the next misalign
//  halted          out  1      state == HALT
//  fetch_count     out  CNT_W  number of pc_valid && pc_ready handshakes (wraps)
// BEHAVIOUR
//  States: BOOT, RUN, HALT. All outputs are registered.
//  Reset values (rst high):
//   - state = BOOT;
//   - pc, misaligned_addr and fetch_count = 0;
//   - pc_valid, misaligned and halted = 0.
//  BOOT: first rising edge with rst low loads pc <= boot_addr, sets pc_valid <= 1 and goes to RUN.
//   All other inputs are ignored in BOOT.
//  RUN: the first matching condition, in this priority order, is applied at each edge:
//   1) trap_req: pc <= trap_vec.
//   2) redirect_valid with redirect_addr[ALIGN_BITS-1:0] != 0:
//      misaligned <= 1, misaligned_addr <= redirect_addr, pc <= trap_vec.
//   3) redirect_valid, aligned: pc <= redirect_addr.
//   4) halt_req: state <= HALT, pc_valid <= 0.
//      pc <= pc+STEP if pc_ready this cycle, otherwise pc is held.
//   5) pc_ready: pc <= pc+STEP.
//   6) otherwise pc is held (stall); pc_valid stays 1.
//  Additional RUN rules:
//   - Trap and redirect take effect regardless of pc_ready; the un-accepted pc is discarded.
//   - pc+STEP is computed modulo 2^XLEN: 0xFFFFFFFC+4 = 0x00000000.
//  HALT: pc_valid = 0 and pc is held. Priority at each edge:
//   1) trap_req.
//   2) redirect (misalign check as in RUN).
//   3) resume_req.
//   Any of these moves to RUN with pc_valid <= 1. For resume, pc is unchanged.
//   halt_req and pc_ready are ignored in HALT.
//  misaligned: high for exactly one cycle after the rejecting edge. Not raised by trap_req.
//  fetch_count: +1 on every edge where pc_valid && pc_ready, counted before the pc update.
//   Wraps at 2^CNT_W.
//  Latency: every input acts at the next rising edge; outputs change one cycle after the inputs.
//  Reset mid-operation: state, pc and all outputs clear immediately (asynchronous).
//   On release, the block re-enters BOOT and reloads boot_addr.
// TESTING
//  - Reset release, boot_addr=0x1000, pc_ready=1 for 3 cycles:
//    pc = 0x1000, 0x1004, 0x1008, 0x100C; fetch_count=3.
//  - pc_ready=0 for 2 cycles in RUN at pc=0x2000:
//    pc held at 0x2000, pc_valid=1, fetch_count unchanged.
//  - redirect_valid=1, redirect_addr=0x3002, trap_vec=0x80:
//    pc=0x80, misaligned pulses 1 cycle, misaligned_addr=0x3002.
//  - trap_req and redirect (0x4000) in the same cycle, trap_vec=0x80: pc=0x80, misaligned=0.
//  - halt_req with pc_ready=1 at pc=0x500:
//    halted=1, pc_valid=0, pc=0x504.
//    resume_req then gives pc_valid=1, pc=0x504.
//  - pc=0xFFFFFFFC, pc_ready=1: pc wraps to 0x0.
//    rst asserted mid-run then released: pc=boot_addr one edge after release.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: boot load, stepped increment under a valid/ready
// handshake, prioritised trap/redirect with misalignment rejection, and halt/resume.
module pc_sequencer #(
    parameter int XLEN       = 32,
    parameter int STEP       = 4,
    parameter int ALIGN_BITS = 2,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  boot_addr,
    input  logic [XLEN-1:0]  trap_vec,
    input  logic             trap_req,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_addr,
    input  logic             halt_req,
    input  logic             resume_req,
    input  logic             pc_ready,
    output logic             pc_valid,
    output logic [XLEN-1:0]  pc,
    output logic             misaligned,
    output logic [XLEN-1:0]  misaligned_addr,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_count
);

    typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} state_t;

    // ALIGN_BITS = 0 yields an all-zero mask, which disables the check.
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);
    localparam logic [XLEN-1:0] STEP_INC   = XLEN'(STEP);

    state_t           state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic             pc_valid_q, pc_valid_d;
    logic             misaligned_q, misaligned_d;
    logic [XLEN-1:0]  misaligned_addr_q, misaligned_addr_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] fetch_count_q, fetch_count_d;

    logic             redirect_bad;
    logic [XLEN-1:0]  pc_inc;

    assign redirect_bad = |(redirect_addr & ALIGN_MASK);
    assign pc_inc       = pc_q + STEP_INC;

    always_comb begin
        state_d           = state_q;
        pc_d              = pc_q;
        pc_valid_d        = pc_valid_q;
        misaligned_d      = 1'b0;
        misaligned_addr_d = misaligned_addr_q;
        fetch_count_d     = fetch_count_q;

        // Count uses the pc offered this cycle, before any pc update.
        if (pc_valid_q && pc_ready) begin
            fetch_count_d = fetch_count_q + CNT_W'(1);
        end

        case (state_q)
            ST_BOOT: begin
                pc_d       = boot_addr;
                pc_valid_d = 1'b1;
                state_d    = ST_RUN;
            end
            ST_RUN, ST_HALT: begin
                if (trap_req) begin
                    pc_d       = trap_vec;
                    pc_valid_d = 1'b1;
                    state_d    = ST_RUN;
                end else if (redirect_valid) begin
                    pc_valid_d = 1'b1;
                    state_d    = ST_RUN;
                    if (redirect_bad) begin
                        misaligned_d      = 1'b1;
                        misaligned_addr_d = redirect_addr;
                        pc_d              = trap_vec;
                    end else begin
                        pc_d = redirect_addr;
                    end
                end else if (state_q == ST_RUN) begin
                    if (halt_req) begin
                        state_d    = ST_HALT;
                        pc_valid_d = 1'b0;
                    end
                    if (pc_ready) begin
                        pc_d = pc_inc;
                    end
                end else if (resume_req) begin
                    state_d    = ST_RUN;
                    pc_valid_d = 1'b1;
                end
            end
            default: begin
                state_d    = ST_BOOT;
                pc_valid_d = 1'b0;
            end
        endcase

        halted_d = (state_d == ST_HALT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= ST_BOOT;
            pc_q              <= '0;
            pc_valid_q        <= 1'b0;
            misaligned_q      <= 1'b0;
            misaligned_addr_q <= '0;
            halted_q          <= 1'b0;
            fetch_count_q     <= '0;
        end else begin
            state_q           <= state_d;
            pc_q              <= pc_d;
            pc_valid_q        <= pc_valid_d;
            misaligned_q      <= misaligned_d;
            misaligned_addr_q <= misaligned_addr_d;
            halted_q          <= halted_d;
            fetch_count_q     <= fetch_count_d;
        end
    end

    assign pc              = pc_q;
    assign pc_valid        = pc_valid_q;
    assign misaligned      = misaligned_q;
    assign misaligned_addr = misaligned_addr_q;
    assign halted          = halted_q;
    assign fetch_count     = fetch_count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus randomized traffic checked
// against a behavioural model of the sequencing rules.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] boot_addr, trap_vec, redirect_addr;
    logic        trap_req, redirect_valid, halt_req, resume_req, pc_ready;
    logic        pc_valid, misaligned, halted;
    logic [31:0] pc, misaligned_addr, fetch_count;

    int n_tests = 0;
    int n_fail  = 0;

    pc_sequencer #(.XLEN(32), .STEP(4), .ALIGN_BITS(2), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .boot_addr(boot_addr), .trap_vec(trap_vec),
        .trap_req(trap_req), .redirect_valid(redirect_valid),
        .redirect_addr(redirect_addr), .halt_req(halt_req), .resume_req(resume_req),
        .pc_ready(pc_ready), .pc_valid(pc_valid), .pc(pc), .misaligned(misaligned),
        .misaligned_addr(misaligned_addr), .halted(halted), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    // Behavioural model: "booted" / "halting" flags rather than a state code.
    bit          m_booted, m_halting, m_vld, m_mis;
    logic [31:0] m_pc, m_maddr, m_cnt;

    task automatic model_reset();
        m_booted = 0; m_halting = 0; m_vld = 0; m_mis = 0;
        m_pc = 0; m_maddr = 0; m_cnt = 0;
    endtask

    task automatic model_edge();
        bit bad;
        bad = redirect_valid && ((redirect_addr % 4) != 0);
        if (m_vld && pc_ready) m_cnt = m_cnt + 1;
        m_mis = 0;
        if (!m_booted) begin
            m_booted = 1; m_pc = boot_addr; m_vld = 1;
        end else if (trap_req || redirect_valid || (m_halting && resume_req)) begin
            if (trap_req)       m_pc = trap_vec;
            else if (bad)       begin m_pc = trap_vec; m_mis = 1; m_maddr = redirect_addr; end
            else if (redirect_valid) m_pc = redirect_addr;
            m_halting = 0; m_vld = 1;
        end else if (!m_halting) begin
            if (pc_ready) m_pc = m_pc + 4;
            if (halt_req) begin m_halting = 1; m_vld = 0; end
        end
    endtask

    task automatic idle_inputs();
        trap_req = 0; redirect_valid = 0; halt_req = 0; resume_req = 0; pc_ready = 0;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; boot_addr = 32'h1000; trap_vec = 32'h80; redirect_addr = 0;
        idle_inputs();
        model_reset();
        @(posedge clk); #1;
        n_tests++;
        if ({pc, pc_valid, misaligned, misaligned_addr, halted, fetch_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: pc=%h vld=%b mis=%b maddr=%h halted=%b cnt=%0d want all zero",
                     pc, pc_valid, misaligned, misaligned_addr, halted, fetch_count);
        end
    endtask

    task automatic test_boot_increment();
        rst = 0; pc_ready = 1;
        tick();
        n_tests++;
        if (pc !== 32'h1000 || pc_valid !== 1'b1) begin
            n_fail++; $display("FAIL boot_load: pc=%h vld=%b want 00001000 1", pc, pc_valid);
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_tests++;
            if (pc !== 32'h1000 + 32'(4 * i)) begin
                n_fail++; $display("FAIL boot_step%0d: pc=%h want %h", i, pc, 32'h1000 + 32'(4 * i));
            end
        end
        n_tests++;
        if (fetch_count !== 32'd3) begin
            n_fail++; $display("FAIL boot_count: got %0d want 3", fetch_count);
        end
    endtask

    task automatic test_stall();
        logic [31:0] cnt0;
        idle_inputs(); redirect_valid = 1; redirect_addr = 32'h2000; pc_ready = 1;
        tick();
        idle_inputs();
        cnt0 = m_cnt;
        n_tests++;
        if (fetch_count !== 32'd4) begin
            n_fail++; $display("FAIL redirect_count: got %0d want 4", fetch_count);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_tests++;
            if (pc !== 32'h2000 || pc_valid !== 1'b1 || fetch_count !== cnt0) begin
                n_fail++; $display("FAIL stall%0d: pc=%h vld=%b cnt=%0d want 00002000 1 %0d",
                                   i, pc, pc_valid, fetch_count, cnt0);
            end
        end
    endtask

    task automatic test_misaligned();
        idle_inputs(); redirect_valid = 1; redirect_addr = 32'h3002; trap_vec = 32'h80;
        tick();
        idle_inputs();
        n_tests++;
        if (pc !== 32'h80 || misaligned !== 1'b1 || misaligned_addr !== 32'h3002) begin
            n_fail++; $display("FAIL misalign: pc=%h mis=%b maddr=%h want 00000080 1 00003002",
                               pc, misaligned, misaligned_addr);
        end
        tick();
        n_tests++;
        if (misaligned !== 1'b0 || misaligned_addr !== 32'h3002 || pc !== 32'h80) begin
            n_fail++; $display("FAIL misalign_pulse: mis=%b maddr=%h pc=%h want 0 00003002 00000080",
                               misaligned, misaligned_addr, pc);
        end
    endtask

    task automatic test_trap_priority();
        idle_inputs(); trap_req = 1; redirect_valid = 1; redirect_addr = 32'h4000;
        trap_vec = 32'h80; pc_ready = 1;
        tick();
        n_tests++;
        if (pc !== 32'h80 || misaligned !== 1'b0) begin
            n_fail++; $display("FAIL trap_over_redirect: pc=%h mis=%b want 00000080 0", pc, misaligned);
        end
        redirect_addr = 32'h4001; trap_vec = 32'h100;
        tick();
        idle_inputs();
        n_tests++;
        if (pc !== 32'h100 || misaligned !== 1'b0 || misaligned_addr !== 32'h3002) begin
            n_fail++; $display("FAIL trap_over_misalign: pc=%h mis=%b maddr=%h want 00000100 0 00003002",
                               pc, misaligned, misaligned_addr);
        end
    endtask

    task automatic test_halt_resume();
        logic [31:0] cnt0;
        idle_inputs(); redirect_valid = 1; redirect_addr = 32'h500;
        tick();
        idle_inputs(); halt_req = 1; pc_ready = 1;
        tick();
        n_tests++;
        if (halted !== 1'b1 || pc_valid !== 1'b0 || pc !== 32'h504) begin
            n_fail++; $display("FAIL halt_enter: halted=%b vld=%b pc=%h want 1 0 00000504",
                               halted, pc_valid, pc);
        end
        cnt0 = fetch_count;
        tick();
        n_tests++;
        if (halted !== 1'b1 || pc !== 32'h504 || fetch_count !== cnt0) begin
            n_fail++; $display("FAIL halt_hold: halted=%b pc=%h cnt=%0d want 1 00000504 %0d",
                               halted, pc, fetch_count, cnt0);
        end
        idle_inputs(); resume_req = 1;
        tick();
        idle_inputs();
        n_tests++;
        if (halted !== 1'b0 || pc_valid !== 1'b1 || pc !== 32'h504) begin
            n_fail++; $display("FAIL resume: halted=%b vld=%b pc=%h want 0 1 00000504",
                               halted, pc_valid, pc);
        end
    endtask

    task automatic test_wrap();
        idle_inputs(); redirect_valid = 1; redirect_addr = 32'hFFFF_FFFC;
        tick();
        idle_inputs(); pc_ready = 1;
        tick();
        idle_inputs();
        n_tests++;
        if (pc !== 32'h0 || pc_valid !== 1'b1) begin
            n_fail++; $display("FAIL pc_wrap: pc=%h vld=%b want 00000000 1", pc, pc_valid);
        end
    endtask

    task automatic test_reset_midrun();
        pc_ready = 1;
        rst = 1; model_reset();
        #1;
        n_tests++;
        if (pc !== 32'h0 || pc_valid !== 1'b0 || fetch_count !== 32'h0 || halted !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: pc=%h vld=%b cnt=%0d halted=%b want 0 0 0 0",
                               pc, pc_valid, fetch_count, halted);
        end
        rst = 0; boot_addr = 32'h0000_7700; trap_req = 1;
        tick();
        trap_req = 0;
        n_tests++;
        if (pc !== 32'h7700 || pc_valid !== 1'b1 || fetch_count !== 32'h0) begin
            n_fail++; $display("FAIL reboot: pc=%h vld=%b cnt=%0d want 00007700 1 0",
                               pc, pc_valid, fetch_count);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            trap_req       = ($urandom_range(0, 15) == 0);
            redirect_valid = ($urandom_range(0, 7) == 0);
            redirect_addr  = $urandom;
            halt_req       = ($urandom_range(0, 9) == 0);
            resume_req     = ($urandom_range(0, 3) == 0);
            pc_ready       = ($urandom_range(0, 2) != 0);
            trap_vec       = $urandom & 32'hFFFF_FFFC;
            boot_addr      = $urandom;
            if ($urandom_range(0, 49) == 0) begin
                rst = 1; model_reset(); #2; rst = 0;
            end
            tick();
            n_tests++;
            if ({pc, pc_valid, misaligned, misaligned_addr, halted, fetch_count} !==
                {m_pc, m_vld, m_mis, m_maddr, m_halting, m_cnt}) begin
                n_fail++;
                $display("FAIL random_%0d: pc=%h vld=%b mis=%b maddr=%h halted=%b cnt=%0d want pc=%h vld=%b mis=%b maddr=%h halted=%b cnt=%0d",
                         i, pc, pc_valid, misaligned, misaligned_addr, halted, fetch_count,
                         m_pc, m_vld, m_mis, m_maddr, m_halting, m_cnt);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_boot_increment();
        test_stall();
        test_misaligned();
        test_trap_priority();
        test_halt_resume();
        test_wrap();
        test_reset_midrun();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
